teller_dispatch: RTL and testbench
==================================

Name: teller_dispatch

Overview:
- Decode-side counterpart of the teller-count encoder. It takes the 2-bit open-teller count (0..3) and expands it to per-teller open bits.
- It accepts customers from the queue front-end through a valid/ready handshake and assigns each one to a free open teller in round-robin order.
- It runs a per-teller service timer. It reports busy/done status per teller and the encoded busy count back to the display/wait-time logic.

Parameters:
- SERVICE_CYCLES, 8, number of cycles a teller stays busy per customer. Legal range is 1..2^TIMER_W.
- TIMER_W, 4, width of each per-teller service timer.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- tcount  input  2  number of open tellers (0..3); tellers 0..tcount-1 are open.
- cust_valid  input  1  queue front has a customer waiting.
- cust_ready  output  1  at least one open teller is free.
- assign  output  3  one-hot grant, high in the handshake cycle only.
- teller_open  output  3  registered thermometer decode of tcount.
- teller_busy  output  3  per-teller busy flags (registered).
- done  output  3  per-teller service-complete pulse.
- busy_count  output  2  popcount of teller_busy (0..3).

Behaviour:
- Clock and reset:
  - One clock (clk). rst is synchronous, active-high, sampled on the rising edge of clk.
  - Reset state: teller_open=000, teller_busy=000, all timers=0, rr_ptr=0.
  - Outputs during and immediately after reset: cust_ready=0, assign=000, done=000, busy_count=00.
- Open decode (registered, 1-cycle latency): tcount 0->000, 1->001, 2->011, 3->111. A change on tcount takes effect on teller_open the following cycle.
- Free tellers:
  - free = teller_open & ~teller_busy, computed from registered state only.
  - cust_ready = |free. This is combinational and does not depend on cust_valid.
- Handshake:
  - A customer is accepted in any cycle with cust_valid & cust_ready.
  - There is no acceptance when cust_ready=0; cust_valid may stay high indefinitely.
  - At most one customer is accepted per cycle.
- Grant selection:
  - Search free starting at index rr_ptr and continue upward with wrap 2->0. The first free teller is granted.
  - assign is the one-hot of the granted index in the accept cycle, and 000 otherwise.
  - On accept, rr_ptr <= (granted+1) mod 3. rr_ptr is unchanged when there is no accept.
- Service timer, for a grant to teller i in cycle k:
  - teller_busy[i] <= 1 and timer[i] <= SERVICE_CYCLES-1.
  - While busy, the timer decrements by 1 each cycle.
  - done[i] = teller_busy[i] & (timer[i]==0), combinational. It is high in cycle k+SERVICE_CYCLES, the last busy cycle.
  - On that edge teller_busy[i] <= 0.
  - teller_busy[i] is high for cycles k+1..k+SERVICE_CYCLES. Teller i is next grantable in cycle k+SERVICE_CYCLES+1.
- Simultaneous completion and request: a teller completing in cycle c is not free in cycle c, because free uses registered busy. It becomes grantable in c+1.
- Closing a busy teller (tcount lowered):
  - The in-progress service completes normally, including its done pulse.
  - The teller is not re-granted while closed.
  - busy_count includes it until completion.
- Opening tellers: a newly opened idle teller is grantable in the cycle after teller_open updates.
- tcount=0: cust_ready stays 0 and no grants occur. Services in progress still finish.
- busy_count = teller_busy[0]+teller_busy[1]+teller_busy[2], combinational from registers. The maximum is 3, so there is no overflow.
- Reset mid-service: all services abort on that edge, no done pulse is produced, and rr_ptr returns to 0.
- SERVICE_CYCLES=1: the timer loads 0, giving one busy cycle with done high in that cycle.

Test Plan:
- Idle rejection: reset, tcount=0, cust_valid=1 held for 20 cycles -> cust_ready=0, assign=000 and busy_count=0 throughout.
- Burst fill: reset, tcount=3, cust_valid=1 held, SERVICE_CYCLES=8.
  - First grant at cycle k: assign 001,010,100 on k,k+1,k+2.
  - cust_ready=0 from k+3; busy_count=3 at k+3.
  - done=001 at k+8; assign=001 again at k+9.
- Round-robin rotation: tcount=3, single-cycle cust_valid pulses 20 cycles apart -> assign sequence 001,010,100,001,010.
- Close while busy: tcount=3, fill all three, then drive tcount=1.
  - teller_open=001 one cycle later.
  - Tellers 1 and 2 still produce done pulses at their scheduled cycles.
  - All subsequent grants are 001 only.
- Reset mid-service: grant teller 0, assert rst 3 cycles later -> teller_busy=000 and busy_count=0 the next cycle, no done pulse, and the next grant is 001.
- Minimum service: SERVICE_CYCLES=1, tcount=1, cust_valid held -> assign=001 every other cycle, done=001 in the cycles between grants.

Source files
------------

// File: rtl/teller_dispatch_if.sv
// teller_dispatch_if: customer handshake and teller status bundle
interface teller_dispatch_if;
   logic [1:0] tcount;
   logic       cust_valid;
   logic       cust_ready;
   logic [2:0] grant;
   logic [2:0] teller_open;
   logic [2:0] teller_busy;
   logic [2:0] done;
   logic [1:0] busy_count;
   modport master (
      output tcount, cust_valid,
      input  cust_ready, grant, teller_open, teller_busy, done, busy_count
   );
   modport slave (
      input  tcount, cust_valid,
      output cust_ready, grant, teller_open, teller_busy, done, busy_count
   );
endinterface

// File: rtl/teller_dispatch.sv
// teller_dispatch: round-robin assignment of customers to open tellers with per-teller service timers
module teller_dispatch #(
   parameter int SERVICE_CYCLES = 8,
   parameter int TIMER_W        = 4
) (
   input logic               clk,
   input logic               rst,
   teller_dispatch_if.slave  bus
);
   localparam logic [TIMER_W-1:0] LOAD = TIMER_W'(SERVICE_CYCLES - 1);
   logic [2:0]         open_q, busy_q, free, grant;
   logic [TIMER_W-1:0] timer [3];
   logic [1:0]         rr_ptr, idx0, idx1, idx2, gidx;
   logic               accept;
   assign free = open_q & ~busy_q;
   assign idx0 = rr_ptr;
   assign idx1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
   assign idx2 = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
   assign gidx = free[idx0] ? idx0 : free[idx1] ? idx1 : idx2;
   assign accept = bus.cust_valid & (|free);
   assign grant = accept ? (3'b001 << gidx) : 3'b000;
   assign bus.cust_ready = |free;
   assign bus.grant = grant;
   assign bus.teller_open = open_q;
   assign bus.teller_busy = busy_q;
   assign bus.busy_count = {1'b0, busy_q[0]} + {1'b0, busy_q[1]} + {1'b0, busy_q[2]};
   // a teller signals completion during its last busy cycle, when its timer has run down
   always_comb begin
      bus.done = 3'b000;
      for (int i = 0; i < 3; i++) bus.done[i] = busy_q[i] & (timer[i] == '0);
   end
   // open decode, round-robin pointer and per-teller service countdown
   always_ff @(posedge clk) begin
      if (rst) begin
         open_q <= 3'b000;
         busy_q <= 3'b000;
         rr_ptr <= 2'd0;
         for (int i = 0; i < 3; i++) timer[i] <= '0;
      end else begin
         open_q <= (bus.tcount == 2'd0) ? 3'b000 :
                   (bus.tcount == 2'd1) ? 3'b001 :
                   (bus.tcount == 2'd2) ? 3'b011 : 3'b111;
         if (accept) rr_ptr <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
         for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
               busy_q[i] <= 1'b1;
               timer[i]  <= LOAD;
            end else if (busy_q[i]) begin
               if (timer[i] == '0) busy_q[i] <= 1'b0;
               else timer[i] <= timer[i] - 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_teller_dispatch.sv
// tb_teller_dispatch: directed stimulus with grant/done scoreboards for the teller dispatcher
module tb_teller_dispatch;
   typedef struct {
      logic [2:0] v;
      int         c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t gq1[$], dq1[$], gq2[$], dq2[$];

   teller_dispatch_if a ();
   teller_dispatch_if b ();

   teller_dispatch #(.SERVICE_CYCLES(8), .TIMER_W(4)) dut (.clk(clk), .rst(rst), .bus(a.slave));
   teller_dispatch #(.SERVICE_CYCLES(1), .TIMER_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at_cyc(input int c);
      wait_cyc(c);
      @(negedge clk);
   endtask

   task automatic push(inout exp_t q[$], input logic [2:0] v, input int c);
      q.push_back('{v: v, c: c});
   endtask

   // scoreboard for the 8-cycle dispatcher: every grant and done pulse must match the next expected one
   always @(negedge clk) begin
      exp_t e;
      if (a.grant != 3'b000) begin
         if (gq1.size() == 0) chk("grant unexpected", int'(a.grant), 0);
         else begin
            e = gq1.pop_front();
            chk("grant value", int'(a.grant), int'(e.v));
            chk("grant cycle", cyc, e.c);
         end
      end
      if (a.done != 3'b000) begin
         if (dq1.size() == 0) chk("done unexpected", int'(a.done), 0);
         else begin
            e = dq1.pop_front();
            chk("done value", int'(a.done), int'(e.v));
            chk("done cycle", cyc, e.c);
         end
      end
   end

   // scoreboard for the single-cycle-service dispatcher
   always @(negedge clk) begin
      exp_t e;
      if (b.grant != 3'b000) begin
         if (gq2.size() == 0) chk("min grant unexpected", int'(b.grant), 0);
         else begin
            e = gq2.pop_front();
            chk("min grant value", int'(b.grant), int'(e.v));
            chk("min grant cycle", cyc, e.c);
         end
      end
      if (b.done != 3'b000) begin
         if (dq2.size() == 0) chk("min done unexpected", int'(b.done), 0);
         else begin
            e = dq2.pop_front();
            chk("min done value", int'(b.done), int'(e.v));
            chk("min done cycle", cyc, e.c);
         end
      end
   end

   initial begin
      int k;
      a.tcount = 2'd0;
      a.cust_valid = 1'b0;
      b.tcount = 2'd0;
      b.cust_valid = 1'b0;
      // reset values and idle rejection with no open tellers
      wait_cyc(3);
      rst = 1'b0;
      @(negedge clk);
      chk("reset ready", int'(a.cust_ready), 0);
      chk("reset open", int'(a.teller_open), 0);
      chk("reset busy", int'(a.teller_busy), 0);
      chk("reset busy_count", int'(a.busy_count), 0);
      chk("reset done", int'(a.done), 0);
      k = cyc + 1;
      wait_cyc(k);
      a.cust_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         at_cyc(k + i);
         chk("idle ready", int'(a.cust_ready), 0);
         chk("idle grant", int'(a.grant), 0);
         chk("idle busy_count", int'(a.busy_count), 0);
      end
      // burst fill of three tellers with valid held
      wait_cyc(k + 21);
      a.cust_valid = 1'b0;
      rst = 1'b1;
      a.tcount = 2'd3;
      wait_cyc(cyc + 1);
      rst = 1'b0;
      k = cyc + 2;
      push(gq1, 3'b001, k);
      push(gq1, 3'b010, k + 1);
      push(gq1, 3'b100, k + 2);
      push(gq1, 3'b001, k + 9);
      push(gq1, 3'b010, k + 10);
      push(gq1, 3'b100, k + 11);
      push(dq1, 3'b001, k + 8);
      push(dq1, 3'b010, k + 9);
      push(dq1, 3'b100, k + 10);
      push(dq1, 3'b001, k + 17);
      push(dq1, 3'b010, k + 18);
      push(dq1, 3'b100, k + 19);
      wait_cyc(k);
      a.cust_valid = 1'b1;
      at_cyc(k + 3);
      chk("burst ready", int'(a.cust_ready), 0);
      chk("burst busy_count", int'(a.busy_count), 3);
      chk("burst busy", int'(a.teller_busy), 7);
      wait_cyc(k + 12);
      a.cust_valid = 1'b0;
      // round-robin rotation with isolated single-cycle requests
      k = k + 22;
      push(gq1, 3'b001, k);
      push(gq1, 3'b010, k + 20);
      push(gq1, 3'b100, k + 40);
      push(gq1, 3'b001, k + 60);
      push(gq1, 3'b010, k + 80);
      push(dq1, 3'b001, k + 8);
      push(dq1, 3'b010, k + 28);
      push(dq1, 3'b100, k + 48);
      push(dq1, 3'b001, k + 68);
      push(dq1, 3'b010, k + 88);
      for (int j = 0; j < 5; j++) begin
         wait_cyc(k + 20 * j);
         a.cust_valid = 1'b1;
         wait_cyc(k + 20 * j + 1);
         a.cust_valid = 1'b0;
      end
      // close two busy tellers; they finish normally and only teller 0 is granted afterwards
      k = k + 100;
      push(gq1, 3'b100, k);
      push(gq1, 3'b001, k + 1);
      push(gq1, 3'b010, k + 2);
      push(gq1, 3'b001, k + 12);
      push(gq1, 3'b001, k + 21);
      push(gq1, 3'b001, k + 30);
      push(dq1, 3'b100, k + 8);
      push(dq1, 3'b001, k + 9);
      push(dq1, 3'b010, k + 10);
      push(dq1, 3'b001, k + 20);
      push(dq1, 3'b001, k + 29);
      push(dq1, 3'b001, k + 38);
      wait_cyc(k);
      a.cust_valid = 1'b1;
      wait_cyc(k + 3);
      a.cust_valid = 1'b0;
      a.tcount = 2'd1;
      at_cyc(k + 3);
      chk("close open before update", int'(a.teller_open), 7);
      at_cyc(k + 4);
      chk("close open", int'(a.teller_open), 1);
      chk("close busy_count", int'(a.busy_count), 3);
      chk("close ready", int'(a.cust_ready), 0);
      wait_cyc(k + 12);
      a.cust_valid = 1'b1;
      wait_cyc(k + 31);
      a.cust_valid = 1'b0;
      // reset in the middle of a service aborts it and rewinds the pointer
      k = k + 42;
      push(gq1, 3'b001, k);
      push(gq1, 3'b001, k + 10);
      push(dq1, 3'b001, k + 18);
      wait_cyc(k);
      a.cust_valid = 1'b1;
      wait_cyc(k + 1);
      a.cust_valid = 1'b0;
      wait_cyc(k + 3);
      rst = 1'b1;
      wait_cyc(k + 4);
      rst = 1'b0;
      a.tcount = 2'd3;
      @(negedge clk);
      chk("rst busy", int'(a.teller_busy), 0);
      chk("rst busy_count", int'(a.busy_count), 0);
      wait_cyc(k + 10);
      a.cust_valid = 1'b1;
      wait_cyc(k + 11);
      a.cust_valid = 1'b0;
      // single-cycle service: grants every other cycle with done in between
      k = k + 22;
      wait_cyc(k - 2);
      b.tcount = 2'd1;
      for (int j = 0; j < 5; j++) begin
         push(gq2, 3'b001, k + 2 * j);
         push(dq2, 3'b001, k + 2 * j + 1);
      end
      wait_cyc(k);
      b.cust_valid = 1'b1;
      at_cyc(k + 1);
      chk("min ready while busy", int'(b.cust_ready), 0);
      chk("min busy_count", int'(b.busy_count), 1);
      wait_cyc(k + 10);
      b.cust_valid = 1'b0;
      at_cyc(k + 14);
      chk("grant queue drained", gq1.size(), 0);
      chk("done queue drained", dq1.size(), 0);
      chk("min grant queue drained", gq2.size(), 0);
      chk("min done queue drained", dq2.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
